// File: rtl/wr_control_pkg.sv
// wr_control_pkg: shared FSM encoding and address-bus geometry for the output-path controllers.
package wr_control_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    localparam int ADDR_W = 8;
    function automatic int data_width(input int n);
        return ADDR_W * n;
    endfunction
endpackage

// File: rtl/wr_control_if.sv
// wr_control_if: start request in, per-bank write enables/addresses and status out.
interface wr_control_if
    import wr_control_pkg::*;
#(
    parameter int width_height = 16
) ();
    localparam int DW = data_width(width_height);
    logic                    active;
    logic [ADDR_W-1:0]       base_addr;
    logic [width_height-1:0] wr_en;
    logic [DW-1:0]           wr_addr;
    logic                    busy;
    logic                    done;
    modport master (output active, base_addr, input wr_en, wr_addr, busy, done);
    modport slave  (input active, base_addr, output wr_en, wr_addr, busy, done);
endinterface

// File: rtl/wr_control_wr_addr_lane.sv
// wr_addr_lane: enable and de-skewed row address for one output bank at pass cycle c.
module wr_addr_lane
    import wr_control_pkg::*;
#(
    parameter int N  = 16,
    parameter int J  = 0,
    parameter int CW = 5
) (
    input  logic [CW-1:0]     c_i,
    input  logic [ADDR_W-1:0] base_i,
    output logic              en_o,
    output logic [ADDR_W-1:0] addr_o
);
    int row;
    always_comb begin
        row    = int'(c_i) - J;
        en_o   = (row >= 0) && (row < N);
        addr_o = en_o ? base_i + ADDR_W'(row) : '0;
    end
endmodule

// File: rtl/wr_control.sv
// wr_control: sequences staggered per-bank writes that de-skew the array's diagonal output.
module wr_control
    import wr_control_pkg::*;
#(
    parameter int width_height = 16
) (
    input  logic         clk,
    input  logic         reset,
    wr_control_if.slave  bus
);
    localparam int DW = data_width(width_height);
    localparam int CW = $clog2(2 * width_height);
    localparam logic [CW-1:0] C_LAST = CW'(2 * width_height - 2);

    state_e                  state_q, state_d;
    logic [CW-1:0]           c_q, c_d;
    logic [ADDR_W-1:0]       base_q, base_d;
    logic [width_height-1:0] en_l, wr_en_q;
    logic [DW-1:0]           addr_l, wr_addr_q;
    logic                    busy_q, done_q;

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        base_d  = base_q;
        unique case (state_q)
            IDLE: if (bus.active) begin
                state_d = RUN;
                c_d     = '0;
                base_d  = bus.base_addr;
            end
            RUN: begin
                state_d = (c_q == C_LAST) ? DONE : RUN;
                c_d     = (c_q == C_LAST) ? c_q : c_q + 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                c_d     = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Lanes look at next-state values so every output can be registered.
    for (genvar j = 0; j < width_height; j++) begin : g_lane
        wr_addr_lane #(.N(width_height), .J(j), .CW(CW)) u_lane (
            .c_i    (c_d),
            .base_i (base_d),
            .en_o   (en_l[j]),
            .addr_o (addr_l[ADDR_W*j +: ADDR_W])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            c_q       <= '0;
            base_q    <= '0;
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            base_q    <= base_d;
            wr_en_q   <= (state_d == RUN) ? en_l : '0;
            wr_addr_q <= (state_d == RUN) ? addr_l : '0;
            busy_q    <= (state_d == RUN);
            done_q    <= (state_d == DONE);
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_wr_control.sv
// tb_wr_control: N=16/4/1 instances against a start-time arithmetic model of the write schedule.
module tb_wr_control;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       active = 1'b0;
    logic [7:0] base_addr = '0;
    always #5 clk = ~clk;

    wr_control_if #(.width_height(16)) if16 ();
    wr_control_if #(.width_height(4))  if4 ();
    wr_control_if #(.width_height(1))  if1 ();
    assign if16.active = active;
    assign if16.base_addr = base_addr;
    assign if4.active = active;
    assign if4.base_addr = base_addr;
    assign if1.active = active;
    assign if1.base_addr = base_addr;

    wr_control #(.width_height(16)) dut16 (.clk(clk), .reset(reset), .bus(if16.slave));
    wr_control #(.width_height(4))  dut4  (.clk(clk), .reset(reset), .bus(if4.slave));
    wr_control #(.width_height(1))  dut1  (.clk(clk), .reset(reset), .bus(if1.slave));

    logic [15:0]  g_en [3];
    logic [127:0] g_addr [3];
    logic         g_busy [3];
    logic         g_done [3];
    always_comb begin
        g_en[0] = if16.wr_en;
        g_en[1] = 16'(if4.wr_en);
        g_en[2] = 16'(if1.wr_en);
        g_addr[0] = if16.wr_addr;
        g_addr[1] = 128'(if4.wr_addr);
        g_addr[2] = 128'(if1.wr_addr);
        g_busy[0] = if16.busy;
        g_busy[1] = if4.busy;
        g_busy[2] = if1.busy;
        g_done[0] = if16.done;
        g_done[1] = if4.done;
        g_done[2] = if1.done;
    end

    int tests = 0;
    int failed = 0;
    int edge_n = 0;
    int nn [3] = '{16, 4, 1};
    int start [3];
    int free_at [3];
    logic [7:0] bq [3];
    int cnt [16][16];
    int sb_total = 0;
    bit sb_on = 1'b0;
    int en_cyc [3] = '{0, 0, 0};
    int done_rel [3] = '{0, 0, 0};

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            start[d] = -1;
            free_at[d] = 0;
        end
    endtask

    // A pass started at edge k occupies 2N edges of output; the next start is legal at k+2N+1.
    task automatic model_edge();
        for (int d = 0; d < 3; d++)
            if (active && edge_n >= free_at[d]) begin
                start[d] = edge_n;
                bq[d] = base_addr;
                free_at[d] = edge_n + 2 * nn[d] + 1;
            end
    endtask

    task automatic expect_of(input int d, output logic [15:0] en, output logic [127:0] addr,
                             output logic busy, output logic done);
        int t;
        int r;
        t = (start[d] < 0) ? -1 : edge_n - start[d];
        en = '0;
        addr = '0;
        for (int j = 0; j < nn[d]; j++) begin
            r = t - j;
            if (t >= 0 && r >= 0 && r < nn[d]) begin
                en[j] = 1'b1;
                addr[8*j +: 8] = bq[d] + 8'(r);
            end
        end
        busy = (t >= 0) && (t <= 2 * nn[d] - 2);
        done = (t == 2 * nn[d] - 1);
    endtask

    task automatic compare_all();
        logic [15:0]  e_en;
        logic [127:0] e_addr;
        logic         e_busy, e_done;
        int           t, r;
        for (int d = 0; d < 3; d++) begin
            expect_of(d, e_en, e_addr, e_busy, e_done);
            check($sformatf("wr_en N=%0d", nn[d]), 128'(g_en[d]), 128'(e_en));
            check($sformatf("wr_addr N=%0d", nn[d]), g_addr[d], e_addr);
            check($sformatf("busy N=%0d", nn[d]), 128'(g_busy[d]), 128'(e_busy));
            check($sformatf("done N=%0d", nn[d]), 128'(g_done[d]), 128'(e_done));
            if (sb_on) begin
                if (g_en[d] != '0) en_cyc[d]++;
                if (g_done[d] && done_rel[d] == 0) done_rel[d] = edge_n - start[d] + 1;
            end
        end
        if (sb_on) begin
            t = edge_n - start[0];
            for (int j = 0; j < 16; j++)
                if (g_en[0][j]) begin
                    r = t - j;
                    sb_total++;
                    if (r >= 0 && r < 16 && g_addr[0][8*j +: 8] == 8'(r)) cnt[j][r]++;
                end
        end
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        if (!reset) model_reset();
        else model_edge();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int bad;
        model_reset();
        for (int j = 0; j < 16; j++)
            for (int r = 0; r < 16; r++) cnt[j][r] = 0;
        repeat (2) step();
        reset = 1'b1;
        repeat (2) step();

        // Basic pass at base 0 with a scoreboard over every (bank,row) write
        sb_on = 1'b1;
        active = 1'b1;
        base_addr = 8'h00;
        step();
        active = 1'b0;
        repeat (38) step();
        sb_on = 1'b0;
        bad = 0;
        for (int j = 0; j < 16; j++)
            for (int r = 0; r < 16; r++) if (cnt[j][r] != 1) bad++;
        check("cover_once", 128'(bad), 128'(0));
        check("cover_total", 128'(sb_total), 128'(256));
        for (int d = 0; d < 3; d++) begin
            check($sformatf("en_cycles N=%0d", nn[d]), 128'(en_cyc[d]), 128'(2 * nn[d] - 1));
            check($sformatf("done_cycle N=%0d", nn[d]), 128'(done_rel[d]), 128'(2 * nn[d]));
        end

        // Wrapping base, with base_addr scrambled while the pass runs
        active = 1'b1;
        base_addr = 8'hF8;
        step();
        active = 1'b0;
        repeat (40) begin
            base_addr = 8'($urandom);
            step();
        end

        // Start held high: back-to-back passes, each capturing whatever base is present
        active = 1'b1;
        repeat (120) begin
            base_addr = 8'($urandom);
            step();
        end

        // Random sparse starts
        repeat (200) begin
            active = ($urandom_range(0, 3) == 0);
            base_addr = 8'($urandom);
            step();
        end
        active = 1'b0;
        repeat (40) step();

        // Asynchronous reset in the middle of a pass at c=10
        active = 1'b1;
        base_addr = 8'($urandom);
        step();
        active = 1'b0;
        for (int i = 0; i < 40 && (edge_n - start[0]) != 10; i++) step();
        check("mid_pass_c10_reached", 128'(edge_n - start[0]), 128'(10));
        reset = 1'b0;
        #1;
        model_reset();
        for (int d = 0; d < 3; d++) begin
            check($sformatf("async_en N=%0d", nn[d]), 128'(g_en[d]), 128'(0));
            check($sformatf("async_addr N=%0d", nn[d]), g_addr[d], 128'(0));
            check($sformatf("async_busy N=%0d", nn[d]), 128'(g_busy[d]), 128'(0));
            check($sformatf("async_done N=%0d", nn[d]), 128'(g_done[d]), 128'(0));
        end
        repeat (2) step();
        reset = 1'b1;
        repeat (20) step();
        active = 1'b1;
        base_addr = 8'($urandom);
        step();
        active = 1'b0;
        repeat (40) step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
